// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// Default widths match the memory side of the 2-way write-back cache.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF   = 28;
  localparam int DATA_W_DEF   = 128;

  localparam int PRIO_RR      = 0;
  localparam int PRIO_FIXED_D = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef logic client_id_t;

  localparam client_id_t CLIENT_I = 1'b0;
  localparam client_id_t CLIENT_D = 1'b1;

  // Returns {op_wr, op_rd}; a client raising both strobes is treated as a write.
  function automatic logic [1:0] decode_op(input logic rd, input logic wr);
    return {wr, rd & ~wr};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Block-transfer memory port as seen by the caches: master drives the strobes,
// slave returns read data and the completion pulse.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output read, write, addr, wdata, input rdata, ready);
  modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational two-way picker; kept generic so a second-level arbiter can reuse it.
module arb_pick_2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_i_i,
  input  logic       req_d_i,
  input  client_id_t last_grant_i,
  input  logic       mode_i,
  output logic       valid_o,
  output client_id_t grant_o
);

  // Select a winner among the current requesters.
  always_comb begin
    valid_o = req_i_i | req_d_i;
    grant_o = CLIENT_I;
    if (req_i_i && req_d_i) begin
      if (mode_i) begin
        grant_o = CLIENT_D;
      end else begin
        grant_o = (last_grant_i == CLIENT_I) ? CLIENT_D : CLIENT_I;
      end
    end else if (req_d_i) begin
      grant_o = CLIENT_D;
    end else begin
      grant_o = CLIENT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single block-wide memory port between I-cache and D-cache.
// A granted transaction is captured and always runs to mem ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
)(
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   i_bus,
  mem_port_arbiter_if.slave   d_bus,
  mem_port_arbiter_if.master  mem_bus
);

  localparam logic MODE_FIXED = (PRIO_MODE == PRIO_FIXED_D) ? 1'b1 : 1'b0;

  arb_state_e        state_q;
  client_id_t        grant_q;
  client_id_t        last_grant_q;
  logic              op_wr_q;
  logic              op_rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              pick_valid;
  client_id_t        pick_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_op;
  logic              busy;
  logic              done;

  arb_pick_2 u_pick (
    .req_i_i      (i_bus.read | i_bus.write),
    .req_d_i      (d_bus.read | d_bus.write),
    .last_grant_i (last_grant_q),
    .mode_i       (MODE_FIXED),
    .valid_o      (pick_valid),
    .grant_o      (pick_id)
  );

  // Route the picked client's request towards the capture registers.
  always_comb begin
    sel_addr  = i_bus.addr;
    sel_wdata = i_bus.wdata;
    sel_op    = decode_op(i_bus.read, i_bus.write);
    if (pick_id == CLIENT_D) begin
      sel_addr  = d_bus.addr;
      sel_wdata = d_bus.wdata;
      sel_op    = decode_op(d_bus.read, d_bus.write);
    end else begin
      sel_addr  = i_bus.addr;
      sel_wdata = i_bus.wdata;
      sel_op    = decode_op(i_bus.read, i_bus.write);
    end
  end

  // Arbitration FSM with request capture; mem ready in IDLE is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= CLIENT_I;
      last_grant_q <= CLIENT_I;
      op_wr_q      <= 1'b0;
      op_rd_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q            <= ST_BUSY;
            grant_q            <= pick_id;
            last_grant_q       <= pick_id;
            addr_q             <= sel_addr;
            wdata_q            <= sel_wdata;
            {op_wr_q, op_rd_q} <= sel_op;
          end
        end
        ST_BUSY: begin
          if (mem_bus.ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign done = busy & mem_bus.ready;

  // Strobes fall in the ready cycle itself so the next grant sees a low gap.
  assign mem_bus.read  = busy & op_rd_q & ~mem_bus.ready;
  assign mem_bus.write = busy & op_wr_q & ~mem_bus.ready;
  assign mem_bus.addr  = addr_q;
  assign mem_bus.wdata = wdata_q;

  assign i_bus.ready = done & (grant_q == CLIENT_I);
  assign d_bus.ready = done & (grant_q == CLIENT_D);
  assign i_bus.rdata = mem_bus.rdata;
  assign d_bus.rdata = mem_bus.rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin instance and fixed-D instance driven by shared stimulus.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [27:0]  i_addr = 28'd0, d_addr = 28'd0;
  logic [127:0] i_wdata = 128'd0, d_wdata = 128'd0, mem_rdata = 128'd0;
  logic         mem_ready = 1'b0;
  logic         sel = 1'b0;
  int           n_total = 0;
  int           n_bad = 0;

  localparam logic [127:0] RD_A5 = {16{8'hA5}};
  localparam logic [127:0] RD_3C = {16{8'h3C}};
  localparam logic [127:0] W1    = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
  localparam logic [127:0] W2    = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] W3    = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;

  mem_port_arbiter_if #(.ADDR_W(28), .DATA_W(128)) i0 (), d0 (), m0 (), i1 (), d1 (), m1 ();

  assign i0.read = i_read;  assign i0.write = i_write; assign i0.addr = i_addr; assign i0.wdata = i_wdata;
  assign d0.read = d_read;  assign d0.write = d_write; assign d0.addr = d_addr; assign d0.wdata = d_wdata;
  assign i1.read = i_read;  assign i1.write = i_write; assign i1.addr = i_addr; assign i1.wdata = i_wdata;
  assign d1.read = d_read;  assign d1.write = d_write; assign d1.addr = d_addr; assign d1.wdata = d_wdata;
  assign m0.rdata = mem_rdata; assign m0.ready = mem_ready;
  assign m1.rdata = mem_rdata; assign m1.ready = mem_ready;

  mem_port_arbiter #(.PRIO_MODE(PRIO_RR), .ADDR_W(28), .DATA_W(128)) dut_rr (
    .clk(clk), .rst_n(rst_n), .i_bus(i0), .d_bus(d0), .mem_bus(m0));
  mem_port_arbiter #(.PRIO_MODE(PRIO_FIXED_D), .ADDR_W(28), .DATA_W(128)) dut_fd (
    .clk(clk), .rst_n(rst_n), .i_bus(i1), .d_bus(d1), .mem_bus(m1));

  logic         o_mr, o_mw, o_ir, o_dr;
  logic [27:0]  o_ma;
  logic [127:0] o_mwd, o_ird, o_drd;
  assign o_mr  = sel ? m1.read  : m0.read;
  assign o_mw  = sel ? m1.write : m0.write;
  assign o_ma  = sel ? m1.addr  : m0.addr;
  assign o_mwd = sel ? m1.wdata : m0.wdata;
  assign o_ir  = sel ? i1.ready : i0.ready;
  assign o_dr  = sel ? d1.ready : d0.ready;
  assign o_ird = sel ? i1.rdata : i0.rdata;
  assign o_drd = sel ? d1.rdata : d0.rdata;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next edge grants; check the strobe, address and captured write data in the first BUSY cycle.
  task automatic grant_chk(input logic wr, input logic [27:0] addr, input logic [127:0] wd);
    logic rd_e;
    rd_e = ~wr;
    tick();
    chk("mem_write", 128'(o_mw), 128'(wr));
    chk("mem_read", 128'(o_mr), 128'(rd_e));
    chk("mem_addr", 128'(o_ma), 128'(addr));
    if (wr) chk("mem_wdata", o_mwd, wd);
    chk("no_rdy_busy", 128'({o_ir, o_dr}), 128'd0);
  endtask

  // Raise mem ready after extra BUSY cycles; only the granted client sees ready.
  task automatic ready_chk(input logic is_d, input logic [127:0] rd, input int extra);
    logic ni;
    ni = ~is_d;
    repeat (extra) tick();
    #1;
    mem_ready = 1'b1;
    mem_rdata = rd;
    #1;
    chk("rdy_i", 128'(o_ir), 128'(ni));
    chk("rdy_d", 128'(o_dr), 128'(is_d));
    chk("strobe_drop", 128'({o_mr, o_mw}), 128'd0);
    chk("rdata", is_d ? o_drd : o_ird, rd);
  endtask

  // Cycle after ready: back in IDLE, strobes and readies low.
  task automatic gap_chk();
    tick();
    mem_ready = 1'b0;
    #1;
    chk("gap_strobe", 128'({o_mr, o_mw}), 128'd0);
    chk("gap_rdy", 128'({o_ir, o_dr}), 128'd0);
  endtask

  initial begin
    #2;
    chk("rst_strobe", 128'({o_mr, o_mw}), 128'd0);
    chk("rst_addr", 128'(o_ma), 128'd0);
    chk("rst_wdata", o_mwd, 128'd0);
    chk("rst_rdy", 128'({o_ir, o_dr}), 128'd0);
    tick();
    rst_n = 1'b1;

    // Single I read with three-cycle memory latency.
    i_read = 1'b1; i_addr = 28'h0000010;
    #1;
    chk("no_strobe_before_grant", 128'(o_mr), 128'd0);
    grant_chk(1'b0, 28'h0000010, 128'd0);
    ready_chk(1'b0, RD_A5, 2);
    i_read = 1'b0;
    gap_chk();

    // Round-robin with both held: D, I, D, I.
    i_read = 1'b1; i_addr = 28'h0000020;
    d_read = 1'b1; d_addr = 28'h0000030;
    for (int k = 0; k < 4; k++) begin
      grant_chk(1'b0, (k % 2 == 0) ? 28'h0000030 : 28'h0000020, 128'd0);
      ready_chk((k % 2 == 0), (k % 2 == 0) ? RD_3C : RD_A5, 0);
      if (k == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
      gap_chk();
    end

    // Withdrawal after grant still completes.
    i_read = 1'b1; i_addr = 28'h0000050;
    grant_chk(1'b0, 28'h0000050, 128'd0);
    i_read = 1'b0;
    tick();
    chk("withdraw_hold", 128'(o_mr), 128'd1);
    ready_chk(1'b0, RD_A5, 0);
    gap_chk();
    tick();
    chk("withdraw_idle", 128'({o_mr, o_mw}), 128'd0);

    // Spurious ready in IDLE, then D read+write issued as a write.
    mem_ready = 1'b1;
    #1;
    chk("spur_rdy", 128'({o_ir, o_dr}), 128'd0);
    tick();
    chk("spur_rdy2", 128'({o_ir, o_dr}), 128'd0);
    chk("spur_strobe", 128'({o_mr, o_mw}), 128'd0);
    mem_ready = 1'b0;
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000060; d_wdata = W2;
    grant_chk(1'b1, 28'h0000060, W2);
    ready_chk(1'b1, RD_3C, 0);
    d_read = 1'b0; d_write = 1'b0;
    gap_chk();

    // Reset between edges mid-BUSY; last_grant was D before reset.
    d_read = 1'b1; d_addr = 28'h0000070;
    grant_chk(1'b0, 28'h0000070, 128'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_strobe", 128'({o_mr, o_mw}), 128'd0);
    d_read = 1'b0;
    tick();
    rst_n = 1'b1;
    i_read = 1'b1; i_addr = 28'h0000080;
    d_read = 1'b1; d_addr = 28'h0000090;
    grant_chk(1'b0, 28'h0000090, 128'd0);
    ready_chk(1'b1, RD_A5, 0);
    i_read = 1'b0; d_read = 1'b0;
    gap_chk();

    // Fixed priority to D: write-back then refill, I held waiting.
    sel = 1'b1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    i_read = 1'b1; i_addr = 28'h0000040;
    d_write = 1'b1; d_addr = 28'h0000100; d_wdata = W1;
    grant_chk(1'b1, 28'h0000100, W1);
    d_wdata = W3;
    tick();
    chk("wdata_captured", o_mwd, W1);
    ready_chk(1'b1, RD_A5, 0);
    d_write = 1'b0; d_read = 1'b1;
    gap_chk();
    grant_chk(1'b0, 28'h0000100, 128'd0);
    ready_chk(1'b1, RD_3C, 0);
    d_read = 1'b0;
    gap_chk();
    grant_chk(1'b0, 28'h0000040, 128'd0);
    ready_chk(1'b0, RD_A5, 0);
    i_read = 1'b0;
    gap_chk();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit main-memory port between the instruction cache (I) and the data cache (D).
- Both clients present the memory-side interface of the 2-way write-back cache: read/write strobes, a 28-bit block address, 128-bit data, and a ready return.
- The arbiter grants one client, captures its request, and drives memory until mem_ready. It then returns ready and read data to that client only.
- Sits between the two caches and the memory model in the CPU top level.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to D.
- ADDR_W, 28, block address width.
- DATA_W, 128, block data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache block read request
- i_write  in  1  I-cache block write request (tied 0 in the current CPU, still supported)
- i_addr  in  ADDR_W  I-cache block address
- i_wdata  in  DATA_W  I-cache write data
- i_rdata  out  DATA_W  read data to I-cache
- i_ready  out  1  transaction-done pulse to I-cache
- d_read  in  1  D-cache block read request
- d_write  in  1  D-cache write-back request
- d_addr  in  ADDR_W  D-cache block address
- d_wdata  in  DATA_W  D-cache write data
- d_rdata  out  DATA_W  read data to D-cache
- d_ready  out  1  transaction-done pulse to D-cache
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory block address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n). Assertion takes effect immediately with no clock required.
- Reset values: state=IDLE, last_grant=I, all captured registers 0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, i_ready=0, d_ready=0.
- States: IDLE, BUSY.
- Request definition: req_X = X_read | X_write.
- Write priority: if a client asserts both read and write, write wins. This is a protocol violation, but the arbiter must stay deterministic.
- IDLE, no request: stay in IDLE.
- IDLE, one requester: grant it.
- IDLE, both requesting, PRIO_MODE=1: grant D.
- IDLE, both requesting, PRIO_MODE=0: grant the client that is not last_grant.
- On grant, at the clock edge:
  - capture the client's addr, wdata and op (write/read) into registers;
  - set grant_id and last_grant;
  - go to BUSY.
- Arbitration latency: one cycle from request to memory strobe.
- BUSY outputs:
  - mem_read = op_rd & ~mem_ready;
  - mem_write = op_wr & ~mem_ready;
  - mem_addr / mem_wdata come from the captured registers.
  - The strobes drop combinationally in the ready cycle, matching the cache convention.
- BUSY with mem_ready=1: X_ready = 1 for the granted client only, combinationally in that same cycle; next state IDLE.
- Read data: X_rdata = mem_rdata for both clients at all times. Clients sample it only with their own ready.
- A new grant can never happen in the ready cycle. Minimum one IDLE cycle between transactions, i.e. mem strobes low for at least one cycle.
- A captured transaction is never aborted. If the granted client drops its request mid-BUSY, the arbiter still completes the memory transaction and pulses ready.
- D-cache write-back followed by refill (two transactions):
  - PRIO_MODE=0: if I is waiting, I is served between them. The D refill waits at most one I transaction.
  - PRIO_MODE=1: D is never interleaved.
- mem_ready asserted in IDLE: ignored. No ready pulse to either client.
- Reset mid-BUSY: strobes drop immediately; the transaction is lost. Clients are reset by the same rst_n.

Decomposition:
- Shared package:
  - state encoding (IDLE, BUSY);
  - client ID constants (CLIENT_I=0, CLIENT_D=1);
  - PRIO_RR / PRIO_FIXED_D constants;
  - default ADDR_W / DATA_W, shared with the cache.
- Sub-module: arb_pick_2, combinational two-way picker. Inputs: req_i, req_d, last_grant, mode. Output: grant ID. It is reused later for a second-level arbiter (e.g. DMA).
- FSM, capture registers and output muxing stay in mem_port_arbiter.

Test Plan:
- Single I read: i_read=1, i_addr=28'h0000010; memory ready after 3 cycles with rdata=128'hA5..A5.
  -> mem_read rises 1 cycle after request, mem_addr=28'h0000010; i_ready pulses 1 cycle with i_rdata=A5..A5; d_ready stays 0.
- Simultaneous requests, PRIO_MODE=0, last_grant=I: d_read and i_read asserted the same cycle.
  -> D served first, then I after one IDLE cycle.
  -> Repeat with both held: grants alternate D, I, D, I.
- PRIO_MODE=1: D write-back (d_addr=28'h0000100, d_wdata=128'h1234…) then D refill, with i_read held throughout.
  -> mem_write then mem_read both to D, then I.
  -> mem_wdata equals the captured value even though d_wdata changes mid-BUSY.
- Request withdrawal: after grant, i_read dropped before mem_ready.
  -> mem_read stays high until mem_ready; i_ready still pulses; arbiter returns to IDLE.
- Spurious mem_ready=1 in IDLE, and read+write asserted together on D.
  -> No ready pulse; the D op is issued as a write.
- rst_n asserted low mid-BUSY between clock edges.
  -> mem_read/mem_write go 0 immediately; after release, the first request is arbitrated with last_grant=I.
